// File: rtl/uart_rx_fifo.sv
// Receive byte FIFO between UART_RX and the bus interface: show-ahead read,
// level/full/empty/overflow status and a level-or-idle-timeout interrupt.
module uart_rx_fifo #(
    parameter int DEPTH   = 16,
    parameter int ADDR_W  = 4,
    parameter int TIMEOUT = 20000,
    parameter int TO_W    = 16
) (
    input  logic              clk,
    input  logic              RST,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    input  logic              rd_en,
    output logic [7:0]        rd_data,
    output logic              empty,
    output logic              full,
    output logic [ADDR_W:0]   level,
    output logic              overflow,
    input  logic              ovf_clr,
    input  logic [ADDR_W:0]   irq_thresh,
    output logic              irq
);

    localparam logic [ADDR_W:0] DEPTH_L   = (ADDR_W+1)'(DEPTH);
    localparam logic [TO_W-1:0] TIMEOUT_L = TO_W'(TIMEOUT);

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [TO_W-1:0]   idle_cnt;
    logic              push_ok;
    logic              pop_ok;
    logic              ovf_evt;
    logic              timeout_hit;

    assign empty   = (level == '0);
    assign full    = (level == DEPTH_L);
    assign pop_ok  = rd_en && !empty;
    // A pop in the same cycle frees the slot, so a push at full still lands.
    assign push_ok = rx_valid && (!full || pop_ok);
    assign ovf_evt = rx_valid && full && !pop_ok;

    assign timeout_hit = (idle_cnt == TIMEOUT_L);
    assign irq = ((irq_thresh != '0) && (level >= irq_thresh)) || timeout_hit;

    assign rd_data = empty ? 8'h00 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= rx_data;
        end
    end

    always_ff @(posedge clk) begin
        if (RST) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            overflow <= 1'b0;
            idle_cnt <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + ADDR_W'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + ADDR_W'(1);
            end
            if (push_ok && !pop_ok) begin
                level <= level + (ADDR_W+1)'(1);
            end else if (pop_ok && !push_ok) begin
                level <= level - (ADDR_W+1)'(1);
            end

            // Set beats clear when both happen in one cycle.
            if (ovf_evt) begin
                overflow <= 1'b1;
            end else if (ovf_clr) begin
                overflow <= 1'b0;
            end

            if (empty || push_ok || pop_ok) begin
                idle_cnt <= '0;
            end else if (!timeout_hit) begin
                idle_cnt <= idle_cnt + TO_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (DEPTH=16, TIMEOUT=8).
module tb_uart_rx_fifo;

    logic       clk;
    logic       RST;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rd_en;
    logic [7:0] rd_data;
    logic       empty;
    logic       full;
    logic [4:0] level;
    logic       overflow;
    logic       ovf_clr;
    logic [4:0] irq_thresh;
    logic       irq;

    int n_checks = 0;
    int n_errors = 0;

    uart_rx_fifo #(
        .DEPTH(16), .ADDR_W(4), .TIMEOUT(8), .TO_W(4)
    ) dut (
        .clk(clk), .RST(RST), .rx_data(rx_data), .rx_valid(rx_valid),
        .rd_en(rd_en), .rd_data(rd_data), .empty(empty), .full(full),
        .level(level), .overflow(overflow), .ovf_clr(ovf_clr),
        .irq_thresh(irq_thresh), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic pop();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic fill16();
        for (int i = 0; i < 16; i++) push(8'(i));
    endtask

    logic [7:0] seq3 [3];

    initial begin
        RST = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; rd_en = 1'b0;
        ovf_clr = 1'b0; irq_thresh = 5'd0;
        seq3[0] = 8'hA5; seq3[1] = 8'h3C; seq3[2] = 8'h7E;
        #1;
        tick(); tick();
        RST = 1'b0;
        tick();

        check("rst_empty", 32'(empty), 32'd1);
        check("rst_full", 32'(full), 32'd0);
        check("rst_level", 32'(level), 32'd0);
        check("rst_rd_data", 32'(rd_data), 32'h00);
        check("rst_irq", 32'(irq), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        pop();
        check("pop_empty_level", 32'(level), 32'd0);
        check("pop_empty_empty", 32'(empty), 32'd1);

        for (int i = 0; i < 3; i++) push(seq3[i]);
        check("three_level", 32'(level), 32'd3);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("three_data%0d", i), 32'(rd_data), 32'(seq3[i]));
            pop();
            check($sformatf("three_level%0d", i), 32'(level), 32'(2 - i));
        end
        check("three_empty", 32'(empty), 32'd1);

        fill16();
        check("fill_full", 32'(full), 32'd1);
        check("fill_level", 32'(level), 32'd16);
        check("fill_irq_off", 32'(irq), 32'd0);
        push(8'hFF);
        check("ovf_set", 32'(overflow), 32'd1);
        check("ovf_level", 32'(level), 32'd16);
        for (int i = 0; i < 16; i++) begin
            check($sformatf("drain_data%0d", i), 32'(rd_data), 32'(i));
            pop();
        end
        check("drain_empty", 32'(empty), 32'd1);
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        check("ovf_clr", 32'(overflow), 32'd0);

        fill16();
        rx_data = 8'hEE; rx_valid = 1'b1; ovf_clr = 1'b1;
        tick();
        rx_valid = 1'b0; ovf_clr = 1'b0;
        check("ovf_set_wins", 32'(overflow), 32'd1);
        check("ovf_set_wins_level", 32'(level), 32'd16);
        ovf_clr = 1'b1; tick(); ovf_clr = 1'b0;
        check("ovf_clr2", 32'(overflow), 32'd0);

        rx_data = 8'h99; rx_valid = 1'b1; rd_en = 1'b1;
        tick();
        rx_valid = 1'b0; rd_en = 1'b0;
        check("full_pp_level", 32'(level), 32'd16);
        check("full_pp_ovf", 32'(overflow), 32'd0);
        for (int i = 1; i < 16; i++) begin
            check($sformatf("full_pp_data%0d", i), 32'(rd_data), 32'(i));
            pop();
        end
        check("full_pp_last", 32'(rd_data), 32'h99);
        pop();
        check("full_pp_empty", 32'(empty), 32'd1);

        rx_data = 8'h99; rx_valid = 1'b1; rd_en = 1'b1;
        tick();
        rx_valid = 1'b0; rd_en = 1'b0;
        check("empty_pp_level", 32'(level), 32'd1);
        check("empty_pp_data", 32'(rd_data), 32'h99);
        pop();

        irq_thresh = 5'd4;
        for (int i = 0; i < 3; i++) push(8'(8'h10 + i));
        check("thr_below", 32'(irq), 32'd0);
        push(8'h13);
        check("thr_reached", 32'(irq), 32'd1);
        pop();
        check("thr_dropped", 32'(irq), 32'd0);
        for (int i = 0; i < 3; i++) pop();
        irq_thresh = 5'd17;
        fill16();
        check("thr_above_depth", 32'(irq), 32'd0);
        for (int i = 0; i < 16; i++) pop();
        irq_thresh = 5'd0;
        check("thr_drain_empty", 32'(empty), 32'd1);

        push(8'h42);
        check("to_level1", 32'(level), 32'd1);
        for (int c = 1; c < 8; c++) begin
            tick();
            check($sformatf("to_wait%0d", c), 32'(irq), 32'd0);
        end
        tick();
        check("to_fire", 32'(irq), 32'd1);
        pop();
        check("to_pop_clr", 32'(irq), 32'd0);

        for (int i = 0; i < 5; i++) push(8'(8'h20 + i));
        check("midfill_level", 32'(level), 32'd5);
        RST = 1'b1; tick(); RST = 1'b0;
        check("midrst_level", 32'(level), 32'd0);
        check("midrst_empty", 32'(empty), 32'd1);
        check("midrst_irq", 32'(irq), 32'd0);
        check("midrst_data", 32'(rd_data), 32'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
